seg_fifo_ctrl: RTL and testbench
================================

SEG_FIFO_CTRL -- requirements
Module: seg_fifo_ctrl

Interface
REQ-001 Parameter WORD, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 128, FIFO depth in words; power of two, >= 4; AW = log2(DEPTH).
REQ-003 Parameter ALMOST, default 2, almost_empty asserted when usedw < ALMOST.
REQ-004 Parameter MIN_LEN, default 4, minimum buffered words for a segment to be launched.
REQ-005 Parameter TIMEOUT, default 4096, RUN-state watchdog limit in cycles (used only with SEG_TIMEOUT_EN).
REQ-006 clk  in  1  clock; all logic rising-edge.
REQ-007 rst_geral  in  1  reset, asynchronous, active-high.
REQ-008 din  in  WORD  signed sample in.
REQ-009 wr_en  in  1  write din this cycle.
REQ-010 trig  in  1  segment trigger (zero-cross flag), level-sampled.
REQ-011 rd_req  in  1  downstream processor read request.
REQ-012 proc_done  in  1  one-cycle pulse: downstream finished segment.
REQ-013 q  out  WORD  FIFO head word, registered.
REQ-014 usedw  out  AW+1  words held, 0..DEPTH.
REQ-015 empty / full / almost_empty  out  1 each  FIFO flags.
REQ-016 seg_len  out  AW+1  latched segment length (usedw-1 at latch).
REQ-017 proc_rst  out  1  reset to downstream processor, active-high.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 ovf  out  1  sticky: write attempted while full.
REQ-020 tmo  out  1  sticky: watchdog expired (0 constant without SEG_TIMEOUT_EN).

Function
REQ-021 FIFO write when wr_en and not full; read when rd_req and not empty; q updates the cycle after an accepted read (1-cycle latency).
REQ-022 Simultaneous accepted read and write leave usedw unchanged; write while full dropped and ovf set; read while empty ignored, q held.
REQ-023 Pointers wrap modulo DEPTH; full = (usedw == DEPTH); empty = (usedw == 0).
REQ-024 FSM states IDLE, ARM, LATCH, RUN.
REQ-025 IDLE: proc_rst=1; next cycle -> ARM.
REQ-026 ARM: proc_rst=1; trig=1 and usedw >= MIN_LEN -> LATCH; trig with usedw < MIN_LEN ignored.
REQ-027 LATCH (one cycle): seg_len <= usedw - 1 using usedw of that cycle; proc_rst=1; -> RUN.
REQ-028 RUN: proc_rst=0; proc_done=1 -> IDLE; trig ignored.
REQ-029 RUN also -> IDLE when almost_empty and not empty and no rd_req in that cycle (segment starved).
REQ-030 proc_rst and busy are registered, decoded from state; proc_rst falls exactly one cycle after LATCH.
REQ-031 seg_len holds its value outside LATCH.

Reset
REQ-032 rst_geral: FIFO emptied, pointers 0, q=0, usedw=0, empty=1, full=0, almost_empty=1, seg_len=0, ovf=0, tmo=0, state IDLE, proc_rst=1, busy=0.
REQ-033 Reset mid-RUN discards FIFO contents and the segment; no clear path other than rst_geral for ovf/tmo.

Configuration
REQ-034 Macro SEG_TIMEOUT_EN defined: counter cleared on entry to RUN, increments each RUN cycle; at TIMEOUT cycles without proc_done -> IDLE, tmo set.
REQ-035 Macro SEG_TIMEOUT_EN undefined: no counter, tmo tied 0, RUN exits only per REQ-028/029.

Structure
REQ-036 Shared package seg_pkg holds the FSM state enum and the default WORD/DEPTH constants.
REQ-037 One sub-module seg_fifo: parametrised synchronous FIFO (REQ-021..023 and flags); FSM, seg_len, watchdog in top.

Verification
REQ-038 Reset, write 10 words, trig=1 (MIN_LEN=4) -> LATCH next cycle, seg_len=9, proc_rst low one cycle after LATCH.
REQ-039 Write 3 words, trig=1 -> stays ARM, proc_rst=1, seg_len=0.
REQ-040 Write DEPTH+1 words with no reads -> full=1, usedw=DEPTH, ovf=1, 129th word not stored.
REQ-041 In RUN, drain with rd_req until usedw=1 (ALMOST=2), rd_req low -> IDLE next cycle, proc_rst=1.
REQ-042 Simultaneous wr_en and rd_req at usedw=5 -> usedw stays 5, q shows old head word next cycle.
REQ-043 SEG_TIMEOUT_EN, TIMEOUT=16, enter RUN, no proc_done, keep usedw>ALMOST -> IDLE after 16 cycles, tmo=1; assert rst_geral mid-RUN -> all REQ-032 values next edge.

Source files
------------

// File: rtl/seg_fifo_ctrl_pkg.sv
// Shared definitions for the segment FIFO controller: FSM state type and
// default geometry. Optional feature macro used by the controller: SEG_TIMEOUT_EN.
package seg_pkg;

    localparam int unsigned SEG_WORD_DEF  = 16;
    localparam int unsigned SEG_DEPTH_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_LATCH,
        ST_RUN
    } seg_state_e;

endpackage

// File: rtl/seg_fifo_ctrl_if.sv
// Sample/handshake bundle between the segment FIFO controller and its user.
// master = producer/consumer side, slave = seg_fifo_ctrl.
interface seg_fifo_ctrl_if
    import seg_pkg::*;
#(
    parameter int unsigned WORD = SEG_WORD_DEF,
    parameter int unsigned AW   = $clog2(SEG_DEPTH_DEF)
);
    logic [WORD-1:0] din;
    logic            wr_en;
    logic            trig;
    logic            rd_req;
    logic            proc_done;
    logic [WORD-1:0] q;
    logic [AW:0]     usedw;
    logic            empty;
    logic            full;
    logic            almost_empty;
    logic [AW:0]     seg_len;
    logic            proc_rst;
    logic            busy;
    logic            ovf;
    logic            tmo;

    modport master (
        output din, wr_en, trig, rd_req, proc_done,
        input  q, usedw, empty, full, almost_empty, seg_len, proc_rst, busy, ovf, tmo
    );

    modport slave (
        input  din, wr_en, trig, rd_req, proc_done,
        output q, usedw, empty, full, almost_empty, seg_len, proc_rst, busy, ovf, tmo
    );
endinterface

// File: rtl/seg_fifo_ctrl_fifo.sv
// seg_fifo: synchronous FIFO with registered head output, occupancy count,
// status flags and a sticky overflow flag.
module seg_fifo #(
    parameter int unsigned WORD   = 16,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ALMOST = 2,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_geral,
    input  logic [WORD-1:0] din,
    input  logic            wr_en,
    input  logic            rd_req,
    output logic [WORD-1:0] q,
    output logic [AW:0]     usedw,
    output logic            empty,
    output logic            full,
    output logic            almost_empty,
    output logic            ovf
);
    logic [WORD-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [WORD-1:0] q_q, q_d;
    logic            ovf_q, ovf_d;
    logic            wr_acc, rd_acc;

    // Flags, accept decisions and next pointer/count/head values.
    always_comb begin
        empty        = (cnt_q == '0);
        full         = (cnt_q == (AW+1)'(DEPTH));
        almost_empty = (cnt_q < (AW+1)'(ALMOST));
        wr_acc       = wr_en && !full;
        rd_acc       = rd_req && !empty;
        wr_ptr_d     = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        q_d          = rd_acc ? mem_q[rd_ptr_q] : q_q;
        ovf_d        = ovf_q | (wr_en & full);
        cnt_d        = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

    // Pointer, count, head and overflow registers.
    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q     = q_q;
    assign usedw = cnt_q;
    assign ovf   = ovf_q;
endmodule

// File: rtl/seg_fifo_ctrl.sv
// seg_fifo_ctrl: sample FIFO plus segment launch FSM (IDLE/ARM/LATCH/RUN).
// Optional RUN-state watchdog enabled by defining SEG_TIMEOUT_EN.
module seg_fifo_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned WORD    = SEG_WORD_DEF,
    parameter int unsigned DEPTH   = SEG_DEPTH_DEF,
    parameter int unsigned ALMOST  = 2,
    parameter int unsigned MIN_LEN = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_geral,
    seg_fifo_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    if ((DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("seg_fifo_ctrl: DEPTH must be a power of two >= 4");
    end
    if ((TIMEOUT < 1) || (TW < 1)) begin : g_bad_timeout
        $error("seg_fifo_ctrl: TIMEOUT must be >= 1");
    end

    seg_fifo #(
        .WORD   (WORD),
        .DEPTH  (DEPTH),
        .ALMOST (ALMOST),
        .AW     (AW)
    ) u_fifo (
        .clk          (clk),
        .rst_geral    (rst_geral),
        .din          (bus.din),
        .wr_en        (bus.wr_en),
        .rd_req       (bus.rd_req),
        .q            (bus.q),
        .usedw        (bus.usedw),
        .empty        (bus.empty),
        .full         (bus.full),
        .almost_empty (bus.almost_empty),
        .ovf          (bus.ovf)
    );

    seg_state_e  state_q, state_d;
    logic [AW:0] seg_len_q, seg_len_d;
    logic        proc_rst_q, proc_rst_d;
    logic        busy_q, busy_d;
    logic        starved;
`ifdef SEG_TIMEOUT_EN
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif

    // Next state, segment length latch, watchdog and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        seg_len_d = seg_len_q;
        starved   = bus.almost_empty && !bus.empty && !bus.rd_req;
`ifdef SEG_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
                if (bus.trig && (bus.usedw >= (AW+1)'(MIN_LEN))) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                seg_len_d = bus.usedw - (AW+1)'(1);
                state_d   = ST_RUN;
`ifdef SEG_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            ST_RUN: begin
`ifdef SEG_TIMEOUT_EN
                tcnt_d = tcnt_q + TW'(1);
`endif
                if (bus.proc_done) begin
                    state_d = ST_IDLE;
`ifdef SEG_TIMEOUT_EN
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
`endif
                end else if (starved) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        proc_rst_d = (state_d != ST_RUN);
        busy_d     = (state_d != ST_IDLE);
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            state_q    <= ST_IDLE;
            seg_len_q  <= '0;
            proc_rst_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_len_q  <= seg_len_d;
            proc_rst_q <= proc_rst_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SEG_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign bus.tmo = tmo_q;
`else
    assign bus.tmo = 1'b0;
`endif

    assign bus.seg_len  = seg_len_q;
    assign bus.proc_rst = proc_rst_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_seg_fifo_ctrl.sv
// Self-checking bench for seg_fifo_ctrl against a queue-based reference model.
// Builds with or without SEG_TIMEOUT_EN.
module tb_seg_fifo_ctrl;
    import seg_pkg::*;

    localparam int unsigned WORD    = 16;
    localparam int unsigned DEPTH   = 128;
    localparam int unsigned AW      = 7;
    localparam int unsigned ALMOST  = 2;
    localparam int unsigned MIN_LEN = 4;
    localparam int unsigned TIMEOUT = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_LATCH = 2;
    localparam int M_RUN   = 3;

    logic clk = 1'b0;
    logic rst_geral;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg_fifo_ctrl_if #(.WORD(WORD), .AW(AW)) bus ();

    seg_fifo_ctrl #(
        .WORD    (WORD),
        .DEPTH   (DEPTH),
        .ALMOST  (ALMOST),
        .MIN_LEN (MIN_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_geral (rst_geral),
        .bus       (bus)
    );

    // reference model
    logic [WORD-1:0] mq[$];
    logic [WORD-1:0] m_q;
    int              m_phase;
    int              m_seg_len;
    int              m_run_cycles;
    bit              m_ovf;
    bit              m_tmo;

    task automatic model_reset();
        mq.delete();
        m_q          = '0;
        m_phase      = M_IDLE;
        m_seg_len    = 0;
        m_run_cycles = 0;
        m_ovf        = 0;
        m_tmo        = 0;
    endtask

    task automatic model_update(input bit wr, input logic [WORD-1:0] d,
                                input bit tr, input bit rd, input bit pd);
        int n;
        n = mq.size();
        if (wr && n == DEPTH) m_ovf = 1;
        case (m_phase)
            M_IDLE:  m_phase = M_ARM;
            M_ARM:   if (tr && n >= MIN_LEN) m_phase = M_LATCH;
            M_LATCH: begin
                m_seg_len    = n - 1;
                m_run_cycles = 0;
                m_phase      = M_RUN;
            end
            default: begin
                m_run_cycles++;
                if (pd) m_phase = M_IDLE;
`ifdef SEG_TIMEOUT_EN
                else if (m_run_cycles == TIMEOUT) begin
                    m_phase = M_IDLE;
                    m_tmo   = 1;
                end
`endif
                else if (n < ALMOST && n > 0 && !rd) m_phase = M_IDLE;
            end
        endcase
        if (rd && n > 0) m_q = mq.pop_front();
        if (wr && n < DEPTH) mq.push_back(d);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("q",            32'(bus.q),            32'(m_q));
        chk("usedw",        32'(bus.usedw),        32'(mq.size()));
        chk("empty",        32'(bus.empty),        32'(mq.size() == 0));
        chk("full",         32'(bus.full),         32'(mq.size() == DEPTH));
        chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() < ALMOST));
        chk("seg_len",      32'(bus.seg_len),      32'(m_seg_len));
        chk("proc_rst",     32'(bus.proc_rst),     32'(m_phase != M_RUN));
        chk("busy",         32'(bus.busy),         32'(m_phase != M_IDLE));
        chk("ovf",          32'(bus.ovf),          32'(m_ovf));
        chk("tmo",          32'(bus.tmo),          32'(m_tmo));
    endtask

    task automatic step(input bit wr, input logic [WORD-1:0] d,
                        input bit tr, input bit rd, input bit pd);
        bus.wr_en     = wr;
        bus.din       = d;
        bus.trig      = tr;
        bus.rd_req    = rd;
        bus.proc_done = pd;
        model_update(wr, d, tr, rd, pd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 0;
        bus.din       = '0;
        bus.trig      = 0;
        bus.rd_req    = 0;
        bus.proc_done = 0;
    endtask

    // asynchronous assertion checked before any edge, then held across one edge
    task automatic do_reset();
        idle_inputs();
        rst_geral = 1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_geral = 0;
    endtask

    task automatic write_n(input int n);
        logic [WORD-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = WORD'($urandom);
            step(1, w, 0, 0, 0);
        end
    endtask

    initial begin
        logic [WORD-1:0] w;
        logic [WORD-1:0] head;
        int wp, rp;

        rst_geral = 1;
        idle_inputs();
        @(posedge clk);
        #1;

        // reset values
        do_reset();
        chk("rst_proc_rst", 32'(bus.proc_rst), 32'd1);
        chk("rst_empty",    32'(bus.empty),    32'd1);

        // launch: 10 words, trigger, latch, run
        write_n(10);
        step(0, '0, 1, 0, 0);
        chk("latch_busy",     32'(bus.busy),     32'd1);
        chk("latch_proc_rst", 32'(bus.proc_rst), 32'd1);
        step(0, '0, 0, 0, 0);
        chk("seg_len_9",     32'(bus.seg_len),  32'd9);
        chk("run_proc_rst",  32'(bus.proc_rst), 32'd0);
        step(0, '0, 1, 0, 0);
        chk("run_trig_ign",  32'(bus.proc_rst), 32'd0);

        // drain to one word, then stop reading: starvation exit
        for (int i = 0; i < 9; i++) step(0, '0, 0, 1, 0);
        chk("drain_usedw", 32'(bus.usedw), 32'd1);
        chk("drain_still_run", 32'(bus.proc_rst), 32'd0);
        step(0, '0, 0, 0, 0);
        chk("starve_proc_rst", 32'(bus.proc_rst), 32'd1);
        chk("starve_busy",     32'(bus.busy),     32'd0);

        // trigger below MIN_LEN is ignored
        do_reset();
        write_n(3);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("short_proc_rst", 32'(bus.proc_rst), 32'd1);
        chk("short_seg_len",  32'(bus.seg_len),  32'd0);
        chk("short_busy",     32'(bus.busy),     32'd1);

        // simultaneous read/write at usedw=5, then read past empty
        do_reset();
        head = 16'h1234;
        step(1, head, 0, 0, 0);
        write_n(4);
        w = 16'hBEEF;
        step(1, w, 0, 1, 0);
        chk("rw_usedw", 32'(bus.usedw), 32'd5);
        chk("rw_head",  32'(bus.q),     32'(head));
        for (int i = 0; i < 5; i++) step(0, '0, 0, 1, 0);
        chk("last_q_beef", 32'(bus.q), 32'(w));
        step(0, '0, 0, 1, 0);
        chk("empty_rd_hold", 32'(bus.q), 32'(w));

        // overflow: DEPTH+1 writes, last one dropped
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = WORD'(i + 100);
            step(1, w, 0, 0, 0);
        end
        chk("ovf_full",  32'(bus.full),  32'd1);
        chk("ovf_usedw", 32'(bus.usedw), 32'(DEPTH));
        chk("ovf_flag",  32'(bus.ovf),   32'd1);
        for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0);
        chk("ovf_last_word", 32'(bus.q),     32'(DEPTH - 1 + 100));
        chk("ovf_drained",   32'(bus.empty), 32'd1);
        chk("ovf_sticky",    32'(bus.ovf),   32'd1);

        // watchdog: RUN without proc_done and with plenty of data
        do_reset();
        write_n(20);
        step(0, '0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, '0, 0, 0, 0);
        chk("wd_before_busy", 32'(bus.busy), 32'd1);
        step(0, '0, 0, 0, 0);
`ifdef SEG_TIMEOUT_EN
        chk("wd_tmo",      32'(bus.tmo),      32'd1);
        chk("wd_busy",     32'(bus.busy),     32'd0);
        chk("wd_proc_rst", 32'(bus.proc_rst), 32'd1);
`else
        chk("wd_tmo",      32'(bus.tmo),      32'd0);
        chk("wd_busy",     32'(bus.busy),     32'd1);
        chk("wd_proc_rst", 32'(bus.proc_rst), 32'd0);
`endif

        // reset in the middle of RUN
        do_reset();
        write_n(20);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        chk("pre_rst_run", 32'(bus.proc_rst), 32'd0);
        do_reset();
        chk("midrun_usedw",   32'(bus.usedw),   32'd0);
        chk("midrun_seg_len", 32'(bus.seg_len), 32'd0);
        chk("midrun_proc_rst", 32'(bus.proc_rst), 32'd1);

        // randomized traffic with varying read/write pressure
        for (int blk = 0; blk < 8; blk++) begin
            wp = $urandom_range(1, 9);
            rp = $urandom_range(1, 9);
            for (int c = 0; c < 300; c++) begin
                w = WORD'($urandom);
                step(($urandom % 10) < wp, w, ($urandom % 4) == 0,
                     ($urandom % 10) < rp, ($urandom % 40) == 0);
            end
            if (blk == 4) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end
endmodule
